// File: rtl/fpq_pkg.sv
// Shared codes and helpers for the frame-priority queue transmit path.
// Timetable codes, frame classes, scheduler states, MTU.
package fpq_pkg;

    typedef enum logic [1:0] {
        T_DEF = 2'b00,
        T_MAR = 2'b01,
        T_PCF = 2'b10,
        T_TT  = 2'b11
    } tt_code_e;

    typedef enum logic [1:0] {
        C_NONE = 2'b00,
        C_TT   = 2'b01,
        C_BE   = 2'b10,
        C_RC   = 2'b11
    } class_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } sched_state_e;

    localparam int MTU_VAL = 95;

    function automatic logic [3:0] rr_next(
        input logic [3:0] idx,
        input int         n
    );
        return (int'(idx) == n - 1) ? 4'd0 : idx + 4'd1;
    endfunction

endpackage

// File: rtl/fpq_tx_scheduler_if.sv
// Launch/done handshake between the scheduler and the MAC transmitter.
// master = scheduler, slave = transmitter.
interface fpq_tx_if;
    import fpq_pkg::*;

    logic       tx_start;
    logic [1:0] tx_class;
    logic [3:0] tx_index;
    logic [7:0] tx_len;
    logic       tx_done;

    modport master (
        output tx_start, tx_class, tx_index, tx_len,
        input  tx_done
    );

    modport slave (
        input  tx_start, tx_class, tx_index, tx_len,
        output tx_done
    );

endinterface

// File: rtl/fpq_rr_pick.sv
// N-wide round-robin picker: first eligible index at or after ptr, wrapping.
// Picks the eligible entry with the smallest forward distance from ptr.
module fpq_rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0] elig,
    input  logic [3:0]   ptr,
    output logic         found,
    output logic [3:0]   idx
);

    int best_d;
    int d;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        best_d = N;
        d      = 0;
        for (int j = 0; j < N; j++) begin
            if (j >= int'(ptr)) d = j - int'(ptr);
            else                d = j + N - int'(ptr);
            if (elig[j] && d < best_d) begin
                best_d = d;
                found  = 1'b1;
                idx    = 4'(j);
            end
        end
    end

endmodule

// File: rtl/fpq_tx_scheduler.sv
// TT/RC/BE transmit scheduler with RR arbitration, timeout and optional
// RC BAG policing (enabled by defining FPQ_RC_BAG_POLICE_EN).
module fpq_tx_scheduler
    import fpq_pkg::*;
#(
    parameter int         N_RC       = 2,
    parameter int         N_BE       = 2,
    parameter logic [7:0] BAG_VAL    = 8'd16,
    parameter logic [11:0] TX_TIMEOUT = 12'd1600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cur_state,
    input  logic [7:0]        cnt_for_TT,
    input  logic [7:0]        cnt_for_RC,
    input  logic              tt_req,
    input  logic [7:0]        tt_len,
    input  logic [N_RC-1:0]   rc_req,
    input  logic [8*N_RC-1:0] rc_len,
    input  logic [N_BE-1:0]   be_req,
    input  logic [8*N_BE-1:0] be_len,
    input  logic              bag_tick,
    fpq_tx_if.master          tx,
    output logic              deq_tt,
    output logic [N_RC-1:0]   deq_rc,
    output logic [N_BE-1:0]   deq_be,
    output logic              busy,
    output logic              tx_abort,
    output logic              err_timeout
);

    sched_state_e state, state_n;

    logic [11:0]     tmo;
    logic [3:0]      rr_rc, rr_be;
    logic            tt_elig;
    logic [N_RC-1:0] rc_elig;
    logic [N_BE-1:0] be_elig;
    logic            rc_found, be_found;
    logic [3:0]      rc_idx, be_idx;

    logic            grant, abort_now;
    class_e          g_class;
    logic [3:0]      g_idx;
    logic [7:0]      g_len;

    logic            start_q;
    logic [1:0]      class_q;
    logic [3:0]      idx_q;
    logic [7:0]      len_q;

    assign tt_elig = tt_req && (cur_state == T_TT)
                  && (tt_len != 8'd0)
                  && (cnt_for_TT >= tt_len);

    for (genvar i = 0; i < N_RC; i++) begin : g_rc
        logic [7:0] len;
        logic       bag_ok;
        assign len = rc_len[8*i +: 8];
`ifdef FPQ_RC_BAG_POLICE_EN
        logic [7:0] bag_cnt;
        // A grant reload beats a same-cycle tick.
        always_ff @(posedge clk) begin
            if (rst)
                bag_cnt <= '0;
            else if (grant && g_class == C_RC
                     && rc_idx == 4'(i))
                bag_cnt <= BAG_VAL;
            else if (bag_tick && bag_cnt != 8'd0)
                bag_cnt <= bag_cnt - 8'd1;
        end
        assign bag_ok = (bag_cnt == 8'd0);
`else
        assign bag_ok = 1'b1;
`endif
        assign rc_elig[i] = rc_req[i] && (len != 8'd0)
                         && (cnt_for_RC >= len) && bag_ok;
    end

`ifndef FPQ_RC_BAG_POLICE_EN
    logic unused_bag_tick;
    assign unused_bag_tick = bag_tick;
`endif

    for (genvar j = 0; j < N_BE; j++) begin : g_be
        logic [7:0] len;
        assign len = be_len[8*j +: 8];
        assign be_elig[j] = be_req[j] && (len != 8'd0)
                         && (cur_state == T_DEF);
    end

    fpq_rr_pick #(.N(N_RC)) u_rc_pick (
        .elig  (rc_elig),
        .ptr   (rr_rc),
        .found (rc_found),
        .idx   (rc_idx)
    );

    fpq_rr_pick #(.N(N_BE)) u_be_pick (
        .elig  (be_elig),
        .ptr   (rr_be),
        .found (be_found),
        .idx   (be_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        grant     = 1'b0;
        abort_now = 1'b0;
        g_class   = C_NONE;
        g_idx     = '0;
        g_len     = '0;
        unique case (state)
            S_IDLE: begin
                if (tt_elig) begin
                    grant   = 1'b1;
                    g_class = C_TT;
                    g_len   = tt_len;
                end else if (rc_found) begin
                    grant   = 1'b1;
                    g_class = C_RC;
                    g_idx   = rc_idx;
                    g_len   = 8'(rc_len >> {rc_idx, 3'b000});
                end else if (be_found) begin
                    grant   = 1'b1;
                    g_class = C_BE;
                    g_idx   = be_idx;
                    g_len   = 8'(be_len >> {be_idx, 3'b000});
                end
                if (grant) state_n = S_BUSY;
            end
            S_BUSY: begin
                // Done wins over a same-cycle expiry.
                if (tx.tx_done) begin
                    state_n = S_IDLE;
                end else if (tmo == 12'd0) begin
                    abort_now = 1'b1;
                    state_n   = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo         <= '0;
            rr_rc       <= '0;
            rr_be       <= '0;
            start_q     <= 1'b0;
            class_q     <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            deq_tt      <= 1'b0;
            deq_rc      <= '0;
            deq_be      <= '0;
            tx_abort    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            start_q  <= grant;
            tx_abort <= abort_now;
            deq_tt   <= grant && g_class == C_TT;
            deq_rc   <= (grant && g_class == C_RC)
                      ? N_RC'(1) << rc_idx : '0;
            deq_be   <= (grant && g_class == C_BE)
                      ? N_BE'(1) << be_idx : '0;
            if (abort_now) err_timeout <= 1'b1;
            if (grant) begin
                class_q <= g_class;
                idx_q   <= g_idx;
                len_q   <= g_len;
                tmo     <= TX_TIMEOUT;
            end else if (state == S_BUSY && !tx.tx_done
                         && tmo != 12'd0) begin
                tmo <= tmo - 12'd1;
            end
            if (grant && g_class == C_RC)
                rr_rc <= rr_next(rc_idx, N_RC);
            if (grant && g_class == C_BE)
                rr_be <= rr_next(be_idx, N_BE);
        end
    end

    assign tx.tx_start = start_q;
    assign tx.tx_class = class_q;
    assign tx.tx_index = idx_q;
    assign tx.tx_len   = len_q;
    assign busy        = (state == S_BUSY);

endmodule

// File: tb/tb_fpq_tx_scheduler.sv
// Directed bench for fpq_tx_scheduler (BAG_VAL=3, TX_TIMEOUT=8).
// Follows FPQ_RC_BAG_POLICE_EN the same way as the RTL build.
module tb_fpq_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cur_state;
  logic [7:0]  cnt_for_TT;
  logic [7:0]  cnt_for_RC;
  logic        tt_req;
  logic [7:0]  tt_len;
  logic [1:0]  rc_req;
  logic [15:0] rc_len;
  logic [1:0]  be_req;
  logic [15:0] be_len;
  logic        bag_tick;
  logic        deq_tt;
  logic [1:0]  deq_rc;
  logic [1:0]  deq_be;
  logic        busy;
  logic        tx_abort;
  logic        err_timeout;

  int n_chk = 0;
  int n_fail = 0;

  fpq_tx_if tx_bus ();

  fpq_tx_scheduler #(
    .N_RC       (2),
    .N_BE       (2),
    .BAG_VAL    (8'd3),
    .TX_TIMEOUT (12'd8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cur_state   (cur_state),
    .cnt_for_TT  (cnt_for_TT),
    .cnt_for_RC  (cnt_for_RC),
    .tt_req      (tt_req),
    .tt_len      (tt_len),
    .rc_req      (rc_req),
    .rc_len      (rc_len),
    .be_req      (be_req),
    .be_len      (be_len),
    .bag_tick    (bag_tick),
    .tx          (tx_bus),
    .deq_tt      (deq_tt),
    .deq_rc      (deq_rc),
    .deq_be      (deq_be),
    .busy        (busy),
    .tx_abort    (tx_abort),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    cur_state      = 2'b00;
    cnt_for_TT     = 8'd0;
    cnt_for_RC     = 8'd0;
    tt_req         = 1'b0;
    tt_len         = 8'd0;
    rc_req         = 2'b00;
    rc_len         = 16'd0;
    be_req         = 2'b00;
    be_len         = 16'd0;
    bag_tick       = 1'b0;
    tx_bus.tx_done = 1'b0;
  endtask

  function automatic logic [28:0] all_out();
    return {tx_bus.tx_start, tx_bus.tx_class,
            tx_bus.tx_index, tx_bus.tx_len,
            deq_tt, deq_rc, deq_be, busy,
            tx_abort, err_timeout};
  endfunction

  task automatic test_reset();
    logic [28:0] o;
    clear_in();
    rst = 1'b1;
    tick();
    tick();
    o = all_out();
    n_chk++;
    if (o !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h want 0", o);
    end
    rst = 1'b0;
    tick();
    n_chk++;
    if (busy !== 1'b0 || tx_bus.tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b start=%b want 0",
               busy, tx_bus.tx_start);
    end
  endtask

  task automatic test_tt_win();
    cur_state  = 2'b11;
    cnt_for_TT = 8'd28;
    cnt_for_RC = 8'd28;
    tt_req     = 1'b1;
    tt_len     = 8'd4;
    rc_req     = 2'b01;
    rc_len     = 16'h0004;
    tick();
    n_chk++;
    if ({tx_bus.tx_start, tx_bus.tx_class, deq_tt,
         deq_rc, busy, tx_bus.tx_len}
        !== {1'b1, 2'b01, 1'b1, 2'b00, 1'b1, 8'd4}) begin
      n_fail++;
      $display("FAIL tt_win: st=%b cl=%b dtt=%b drc=%b bz=%b len=%0d",
               tx_bus.tx_start, tx_bus.tx_class, deq_tt,
               deq_rc, busy, tx_bus.tx_len);
    end
    tt_req = 1'b0;
    rc_req = 2'b00;
    tx_bus.tx_done = 1'b1;
    tick();
    tx_bus.tx_done = 1'b0;
    n_chk++;
    if (tx_bus.tx_start !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tt_done: start=%b busy=%b want 0 0",
               tx_bus.tx_start, busy);
    end
    n_chk++;
    if (tx_bus.tx_class !== 2'b01 || tx_bus.tx_len !== 8'd4) begin
      n_fail++;
      $display("FAIL tt_hold: class=%b len=%0d want 01 4",
               tx_bus.tx_class, tx_bus.tx_len);
    end
    clear_in();
  endtask

  task automatic test_window_fit();
    cur_state  = 2'b01;
    cnt_for_RC = 8'd7;
    rc_req     = 2'b11;
    rc_len     = {8'd8, 8'd9};
    tick();
    tick();
    n_chk++;
    if (tx_bus.tx_start !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL win_closed: start=%b busy=%b want 0 0",
               tx_bus.tx_start, busy);
    end
    cnt_for_RC = 8'd8;
    tick();
    n_chk++;
    if ({tx_bus.tx_start, tx_bus.tx_class, tx_bus.tx_index,
         tx_bus.tx_len, deq_rc}
        !== {1'b1, 2'b11, 4'd1, 8'd8, 2'b10}) begin
      n_fail++;
      $display("FAIL win_fit: st=%b cl=%b idx=%0d len=%0d drc=%b",
               tx_bus.tx_start, tx_bus.tx_class,
               tx_bus.tx_index, tx_bus.tx_len, deq_rc);
    end
    rc_req = 2'b00;
    tx_bus.tx_done = 1'b1;
    tick();
    clear_in();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_idx [3];
    exp_idx[0] = 4'd0;
    exp_idx[1] = 4'd1;
    exp_idx[2] = 4'd0;
    cur_state = 2'b00;
    be_req    = 2'b11;
    be_len    = {8'd6, 8'd5};
    tick();
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (tx_bus.tx_start !== 1'b1 || tx_bus.tx_class !== 2'b10
          || tx_bus.tx_index !== exp_idx[k]
          || deq_be !== (2'b01 << exp_idx[k])) begin
        n_fail++;
        $display("FAIL rr_be[%0d]: st=%b cl=%b idx=%0d dbe=%b want idx %0d",
                 k, tx_bus.tx_start, tx_bus.tx_class,
                 tx_bus.tx_index, deq_be, exp_idx[k]);
      end
      tick();
      tick();
      tick();
      n_chk++;
      if (busy !== 1'b1 || tx_bus.tx_start !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_busy[%0d]: busy=%b start=%b want 1 0",
                 k, busy, tx_bus.tx_start);
      end
      if (k == 2) cur_state = 2'b10;
      tx_bus.tx_done = 1'b1;
      tick();
      tx_bus.tx_done = 1'b0;
      n_chk++;
      if (tx_bus.tx_start !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_gap[%0d]: start=%b want 0",
                 k, tx_bus.tx_start);
      end
      tick();
    end
    n_chk++;
    if (tx_bus.tx_start !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL be_pcf: start=%b busy=%b want 0 0",
               tx_bus.tx_start, busy);
    end
    cur_state = 2'b01;
    tick();
    tick();
    n_chk++;
    if (tx_bus.tx_start !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL be_mar: start=%b busy=%b want 0 0",
               tx_bus.tx_start, busy);
    end
    clear_in();
  endtask

  task automatic test_bag();
    cur_state  = 2'b01;
    cnt_for_RC = 8'd20;
    rc_req     = 2'b01;
    rc_len     = 16'h0004;
    tick();
    n_chk++;
    if (tx_bus.tx_start !== 1'b1 || tx_bus.tx_class !== 2'b11
        || tx_bus.tx_index !== 4'd0 || deq_rc !== 2'b01) begin
      n_fail++;
      $display("FAIL bag_first: st=%b cl=%b idx=%0d drc=%b",
               tx_bus.tx_start, tx_bus.tx_class,
               tx_bus.tx_index, deq_rc);
    end
    tx_bus.tx_done = 1'b1;
    tick();
    tx_bus.tx_done = 1'b0;
    tick();
`ifdef FPQ_RC_BAG_POLICE_EN
    tick();
    tick();
    n_chk++;
    if (tx_bus.tx_start !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bag_hold: start=%b busy=%b want 0 0",
               tx_bus.tx_start, busy);
    end
    for (int k = 0; k < 3; k++) begin
      bag_tick = 1'b1;
      tick();
      bag_tick = 1'b0;
      n_chk++;
      if (tx_bus.tx_start !== 1'b0) begin
        n_fail++;
        $display("FAIL bag_tick[%0d]: start=%b want 0",
                 k, tx_bus.tx_start);
      end
      tick();
      if (k == 2) begin
        n_chk++;
        if (tx_bus.tx_start !== 1'b1 || tx_bus.tx_index !== 4'd0) begin
          n_fail++;
          $display("FAIL bag_regrant: start=%b idx=%0d want 1 0",
                   tx_bus.tx_start, tx_bus.tx_index);
        end
      end
    end
`else
    n_chk++;
    if (tx_bus.tx_start !== 1'b1 || tx_bus.tx_index !== 4'd0) begin
      n_fail++;
      $display("FAIL rc_regrant: start=%b idx=%0d want 1 0",
               tx_bus.tx_start, tx_bus.tx_index);
    end
`endif
    rc_req = 2'b00;
    tx_bus.tx_done = 1'b1;
    tick();
    clear_in();
  endtask

  task automatic test_timeout();
    cur_state  = 2'b11;
    cnt_for_TT = 8'd28;
    tt_req     = 1'b1;
    tt_len     = 8'd4;
    tick();
    tt_req = 1'b0;
    n_chk++;
    if (tx_bus.tx_start !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_start: start=%b want 1", tx_bus.tx_start);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_chk++;
      if (tx_abort !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL tmo_wait[%0d]: abort=%b busy=%b want 0 1",
                 k, tx_abort, busy);
      end
    end
    tick();
    n_chk++;
    if ({tx_abort, err_timeout, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL tmo_abort: abort=%b err=%b busy=%b want 1 1 0",
               tx_abort, err_timeout, busy);
    end
    tick();
    n_chk++;
    if (tx_abort !== 1'b0 || err_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_sticky: abort=%b err=%b want 0 1",
               tx_abort, err_timeout);
    end
    tt_req = 1'b1;
    tick();
    tt_req = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    tx_bus.tx_done = 1'b1;
    tick();
    tx_bus.tx_done = 1'b0;
    n_chk++;
    if (tx_abort !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_done_wins: abort=%b busy=%b want 0 0",
               tx_abort, busy);
    end
    clear_in();
  endtask

  task automatic test_reset_mid_busy();
    logic [28:0] o;
    cur_state  = 2'b11;
    cnt_for_TT = 8'd28;
    tt_req     = 1'b1;
    tt_len     = 8'd4;
    tick();
    tick();
    rst = 1'b1;
    tick();
    o = all_out();
    n_chk++;
    if (o !== 29'd0) begin
      n_fail++;
      $display("FAIL rst_mid: got %h want 0", o);
    end
    rst = 1'b0;
    tick();
    n_chk++;
    if (tx_bus.tx_start !== 1'b1 || deq_tt !== 1'b1
        || tx_abort !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_regrant: st=%b dtt=%b abort=%b want 1 1 0",
               tx_bus.tx_start, deq_tt, tx_abort);
    end
    tt_req = 1'b0;
    tx_bus.tx_done = 1'b1;
    tick();
    clear_in();
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    test_reset();
    test_tt_win();
    test_window_fit();
    test_round_robin();
    test_bag();
    test_timeout();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fpq_tx_scheduler.md
# fpq_tx_scheduler

Transmit scheduler for the frame-priority queue path. It sits between the queue servers and the shared MAC transmitter. Each cycle it checks the timetable window (`cur_state`, `cnt_for_TT`, `cnt_for_RC`) against the pending TT, RC and BE heads. It grants exactly one frame at a time, applies RC bandwidth-allocation-gap (BAG) policing, and sequences the transmitter with a start/done handshake and a timeout.

## Interface
Parameters:
- `N_RC`, 2 — number of RC queues (1..16).
- `N_BE`, 2 — number of BE queues (1..16).
- `BAG_VAL`, 8'd16 — BAG reload value, in `bag_tick` units.
- `TX_TIMEOUT`, 12'd1600 — clk cycles allowed in BUSY before abort.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `cur_state` in 2 — timetable type code: 00 DEF, 01 MAR, 11 TT, 10 PCF.
- `cnt_for_TT` in 8 — residual TT window, 16 B units.
- `cnt_for_RC` in 8 — residual RC window, 16 B units.
- `tt_req` in 1 — TT head valid.
- `tt_len` in 8 — TT head length, 16 B units.
- `rc_req` in N_RC — RC head valid per queue.
- `rc_len` in 8*N_RC — RC head lengths; queue i occupies bits [8i+7:8i].
- `be_req` in N_BE — BE head valid per queue.
- `be_len` in 8*N_BE — BE head lengths, same packing.
- `bag_tick` in 1 — one-cycle BAG time base.
- `tx_done` in 1 — transmitter finished the current frame.
- `tx_start` out 1 — one-cycle launch pulse.
- `tx_class` out 2 — class of the launched frame: 01 TT, 11 RC, 10 BE.
- `tx_index` out 4 — queue index within the class.
- `tx_len` out 8 — length of the launched frame.
- `deq_tt` out 1 — dequeue pulse for the TT queue.
- `deq_rc` out N_RC — dequeue pulses for RC queues.
- `deq_be` out N_BE — dequeue pulses for BE queues.
- `busy` out 1 — high while state is BUSY.
- `tx_abort` out 1 — one-cycle pulse on timeout.
- `err_timeout` out 1 — sticky timeout flag.

## Operation
- States: S_IDLE, S_BUSY.
- Eligibility, evaluated combinationally in S_IDLE:
  - TT: `tt_req` && `cur_state`==11 && `tt_len`!=0 && `cnt_for_TT` >= `tt_len`.
  - RC i: `rc_req[i]` && `rc_len[i]`!=0 && `cnt_for_RC` >= `rc_len[i]` && `bag_cnt[i]`==0.
  - BE j: `be_req[j]` && `be_len[j]`!=0 && `cur_state`==00.
  - PCF and MAR windows never admit BE. A zero length is never eligible.
- Priority: TT > RC > BE.
  - RC and BE each use a round-robin pointer (`rr_rc`, `rr_be`). The first eligible index at or after the pointer, with wrap N-1→0, wins.
- Grant in S_IDLE with any eligible request:
  - Next cycle: `tx_start`=1, the matching `deq_*` bit=1, and `tx_class`/`tx_index`/`tx_len` registered.
  - State moves to S_BUSY and the timeout counter loads `TX_TIMEOUT`.
  - The RR pointer of the served class moves to index+1 (wrapping).
  - For an RC grant, `bag_cnt[i]` loads `BAG_VAL`.
- S_BUSY:
  - `tx_done`=1 → S_IDLE; `tx_class`/`tx_index`/`tx_len` hold until the next grant.
  - Timeout counter reaching 0 with no `tx_done` → `tx_abort` pulse, `err_timeout`<=1, S_IDLE.
  - Otherwise the timeout counter decrements.
  - Requests are ignored; there is no preemption.
- BAG counters: decrement by 1 on `bag_tick`, saturating at 0. When a load and a tick hit the same cycle, the load wins.
- Arithmetic: all compares are unsigned 8-bit. `tx_index` is zero-extended to 4 bits.

## Timing
- Reset (`rst`=1 at a rising edge): every output goes to 0; state=S_IDLE; RR pointers=0; all `bag_cnt`=0; timeout counter=0. Reset mid-frame drops the frame silently, with no `tx_abort`.
- Grant latency: eligibility sampled in cycle N → `tx_start`/`deq_*` in cycle N+1.
- `tx_done` is sampled only in S_BUSY and is ignored in S_IDLE. `tx_done` in the first BUSY cycle is accepted.
- Minimum gap: `tx_done` in cycle M → S_IDLE in cycle M+1 → next `tx_start` no earlier than M+2.
- `tx_done` and timeout expiry in the same cycle: done wins; no abort, no error.
- `busy` is high from the `tx_start` cycle through the cycle `tx_done` is sampled.
- The window can close between eligibility and launch; the frame is still launched, since the guard band belongs to the timetable.

## Configuration
- `FPQ_RC_BAG_POLICE_EN` defined: BAG counters exist and gate RC eligibility as above.
- Undefined: no BAG counters; `bag_tick` is unused; RC eligibility is `rc_req`, nonzero length and window fit only.

## Structure
- Shared package `fpq_pkg` holds:
  - Timetable codes T_DEF, T_MAR, T_TT, T_PCF.
  - Class codes C_TT, C_RC, C_BE.
  - MTU_VAL=95.
- One sub-module `fpq_rr_pick`: a parameterised N-wide round-robin picker. Inputs are an eligibility vector and a pointer; outputs are a found flag and an index. It is instantiated once for RC and once for BE.

## Test plan
- TT win: `cur_state`=11, `cnt_for_TT`=28, `tt_len`=4, `rc_req`=01, `rc_len[0]`=4 → next cycle `tx_start`, `tx_class`=01, `deq_tt`=1, `deq_rc`=0.
- Window fit: `cur_state`=01, `cnt_for_RC`=8, `rc_len[0]`=9, `rc_len[1]`=8, both requesting → grant RC1, `tx_len`=8. With `cnt_for_RC`=7, no grant and `busy` stays 0.
- Round robin: `cur_state`=00, both BE requesting, `tx_done` 3 cycles after each start → `tx_index` sequence 0,1,0. BE is never granted while `cur_state`=10 or 01.
- BAG (macro on), `BAG_VAL`=3: RC0 is served, then re-requests; no RC0 grant until 3 `bag_tick` pulses. With the macro off, regranted 2 cycles after `tx_done`.
- Timeout, `TX_TIMEOUT`=8: no `tx_done` after start → `tx_abort` 9 cycles after `tx_start`, `err_timeout`=1 sticky. With `tx_done` arriving on the expiry cycle → no abort.
- Reset mid-BUSY: `rst` asserted → all outputs 0 next cycle; after release, a pending TT request is granted 1 cycle after eligibility.
